// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encoding and default operand/counter/product widths.
package shift_add_multiplier_pkg;

  // Operand width. The datapath adder is a fixed four_bit_adder, so 4 is the only legal value.
  localparam int WIDTH_DEFAULT     = 4;
  // The iteration counter must be able to hold 0..WIDTH.
  localparam int COUNT_W_DEFAULT   = 3;
  localparam int PRODUCT_W_DEFAULT = 2 * WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// four_bit_adder: combinational 4-bit ripple-carry adder.
// It forms each partial-product step of the multiplier.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] carry;

  assign carry[0] = carry_in;

  // One full adder per bit position, with the carry rippling towards the MSB.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign carry_out = carry[4];

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned 4x4 shift-and-add multiplier.
// It produces an 8-bit product and uses a start/busy/done handshake.
// Each RUN cycle adds the multiplicand into the high accumulator when
// the multiplier LSB is set. {carry, sum, mq} then shifts right by one.
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand goes straight to
// DONE with a zero product, without passing through RUN.
//
// Port buses are numbered MSB-first ([0:N-1], bit 0 = MSB). Internally,
// values are held LSB-first ([N-1:0]). The ports connect position by
// position, so the MSB of the port drives the MSB of the register. The
// multiplier LSB is therefore mq_reg[0] inside this module.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [0:WIDTH-1]     a,
  input  logic [0:WIDTH-1]     b,
  output logic                 busy,
  output logic                 done,
  output logic [0:2*WIDTH-1]   product
);

  localparam int                 PRODUCT_W  = 2 * WIDTH;
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

  state_t               state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     acc_hi_reg;
  logic [WIDTH-1:0]     mq_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [PRODUCT_W-1:0] product_reg;

  logic [WIDTH-1:0]     a_num;
  logic [WIDTH-1:0]     b_num;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry_out;
  logic [WIDTH-1:0]     acc_hi_next;
  logic [WIDTH-1:0]     mq_next;

  // Operands in LSB-first numeric form.
  assign a_num = a;
  assign b_num = b;

  // Add the multiplicand only when the current multiplier LSB is 1.
  assign addend = mq_reg[0] ? mcand_reg : '0;

  four_bit_adder u_adder (
    .a         (acc_hi_reg),
    .b         (addend),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Shift the 5-bit sum and mq right as one register. The sum LSB moves into
  // the mq MSB, and carry_out fills the accumulator MSB. A 4x4 product fits
  // in eight bits, so the carry can never be lost.
  assign acc_hi_next = {carry_out, sum[WIDTH-1:1]};
  assign mq_next     = {sum[0], mq_reg[WIDTH-1:1]};

  // Control FSM, shift registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      mq_reg      <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        // DONE accepts a new start exactly like IDLE does, which allows back-to-back issue.
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (start) begin
            mcand_reg  <= a_num;
            mq_reg     <= b_num;
            acc_hi_reg <= '0;
            count_reg  <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            if ((a_num == '0) || (b_num == '0)) begin
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              product_reg <= '0;
            end else begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
            end
`else
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
`endif
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        // One add/shift step per cycle. A start request is ignored here.
        ST_RUN: begin
          acc_hi_reg <= acc_hi_next;
          mq_reg     <= mq_next;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST_COUNT) begin
            state_reg   <= ST_DONE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            product_reg <= {acc_hi_next, mq_next};
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Expected products are pushed to a scoreboard queue when a start is driven.
// They are popped and compared when done is observed.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [0:3] a;
  logic [0:3] b;
  logic       busy;
  logic       done;
  logic [0:7] product;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  shift_add_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle, push the expected product, then scramble the operands.
  task automatic do_start(input logic [3:0] av, input logic [3:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(8'(av) * 8'(bv));
    tick();
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
  endtask

  // Count cycles from the accepting edge until done. lat starts at 1 for that edge.
  task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
    lat      = 1;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    total++;
    if (product !== 8'h00) begin
      bad++;
      $display("FAIL reset_product: got %b want 00000000", product);
    end
    $display("reset: busy=%b done=%b product=%b", busy, done, product);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int         lat;
    int         bc;
    bit         ok;
    logic [7:0] ev;
    do_start(4'b0011, 4'b0101);
    total++;
    if (product !== 8'h00) begin
      bad++;
      $display("FAIL basic_product_stable: got %b want 00000000", product);
    end
    wait_done(lat, bc, ok);
    ev = exp_q.pop_front();
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout: no done after %0d cycles", lat);
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    total++;
    if (bc != 4) begin
      bad++;
      $display("FAIL basic_busy_cycles: got %0d want 4", bc);
    end
    total++;
    if (product !== ev) begin
      bad++;
      $display("FAIL basic_product: got %b want %b", product, ev);
    end
    $display("basic 3*5: product=%b latency=%0d busy=%0d", product, lat, bc);
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_single_pulse: done=%b want 0", done);
    end
    total++;
    if (product !== ev) begin
      bad++;
      $display("FAIL basic_product_hold: got %b want %b", product, ev);
    end
  endtask

  task automatic test_back_to_back();
    int         lat;
    int         bc;
    bit         ok;
    logic [7:0] ev;
    do_start(4'b1111, 4'b1111);
    wait_done(lat, bc, ok);
    ev = exp_q.pop_front();
    total++;
    if (!ok || product !== ev) begin
      bad++;
      $display("FAIL b2b_first: ok=%0d got %b want %b", ok, product, ev);
    end
    $display("b2b 15*15: product=%b latency=%0d", product, lat);
    // Now in the DONE cycle: hold start high here.
    do_start(4'b0010, 4'b0011);
    wait_done(lat, bc, ok);
    ev = exp_q.pop_front();
    total++;
    if (!ok || lat != 5) begin
      bad++;
      $display("FAIL b2b_latency: ok=%0d got %0d want 5", ok, lat);
    end
    total++;
    if (product !== ev) begin
      bad++;
      $display("FAIL b2b_second: got %b want %b", product, ev);
    end
    $display("b2b 2*3: product=%b latency=%0d", product, lat);
    tick();
  endtask

  task automatic test_ignored_start();
    int         lat;
    int         extra;
    logic [7:0] ev;
    do_start(4'b1010, 4'b0110);
    lat = 1;
    tick();
    lat = 2;
    start = 1'b1;
    a     = 4'b0001;
    b     = 4'b0001;
    tick();
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    ev = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || lat != 5) begin
      bad++;
      $display("FAIL ignore_latency: done=%b got %0d want 5", done, lat);
    end
    total++;
    if (product !== ev) begin
      bad++;
      $display("FAIL ignore_product: got %b want %b", product, ev);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_extra_done: got %0d pulses want 0", extra);
    end
    $display("ignore 10*6: product=%b latency=%0d extra=%0d", product, lat, extra);
  endtask

  task automatic test_reset_mid_run();
    int         lat;
    int         bc;
    int         extra;
    bit         ok;
    logic [7:0] ev;
    do_start(4'b0111, 4'b1001);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_front());
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_flags: busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (product !== 8'h00) begin
      bad++;
      $display("FAIL midreset_product: got %b want 00000000", product);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL midreset_activity: got %0d active cycles want 0", extra);
    end
    do_start(4'b1100, 4'b1011);
    wait_done(lat, bc, ok);
    ev = exp_q.pop_front();
    total++;
    if (!ok || lat != 5 || product !== ev) begin
      bad++;
      $display("FAIL midreset_restart: ok=%0d lat=%0d got %b want %b", ok, lat, product, ev);
    end
    $display("midreset then 12*11: product=%b latency=%0d", product, lat);
    tick();
  endtask

  task automatic test_zero_operand();
    int         lat;
    int         bc;
    bit         ok;
    logic [7:0] ev;
    logic [3:0] za[2];
    logic [3:0] zb[2];
    int         want_lat;
    int         want_busy;
`ifdef MUL_ZERO_BYPASS_EN
    want_lat  = 1;
    want_busy = 0;
`else
    want_lat  = 5;
    want_busy = 4;
`endif
    za[0] = 4'b0000;
    zb[0] = 4'b1001;
    za[1] = 4'b0101;
    zb[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      // Leave a known non-zero product in place, so a zero result is a real change.
      do_start(4'b1101, 4'b0011);
      wait_done(lat, bc, ok);
      void'(exp_q.pop_front());
      tick();
      do_start(za[i], zb[i]);
      wait_done(lat, bc, ok);
      ev = exp_q.pop_front();
      total++;
      if (!ok || lat != want_lat) begin
        bad++;
        $display("FAIL zero_latency: ok=%0d got %0d want %0d", ok, lat, want_lat);
      end
      total++;
      if (bc != want_busy) begin
        bad++;
        $display("FAIL zero_busy: got %0d want %0d", bc, want_busy);
      end
      total++;
      if (product !== ev) begin
        bad++;
        $display("FAIL zero_product: got %b want %b", product, ev);
      end
      $display("zero %b*%b: product=%b latency=%0d busy=%0d", za[i], zb[i], product, lat, bc);
      tick();
    end
  endtask

  task automatic test_random();
    int         lat;
    int         bc;
    bit         ok;
    logic [7:0] ev;
    logic [3:0] av;
    logic [3:0] bv;
    for (int i = 0; i < 8; i++) begin
      av = 4'($urandom_range(1, 15));
      bv = 4'($urandom_range(1, 15));
      do_start(av, bv);
      wait_done(lat, bc, ok);
      ev = exp_q.pop_front();
      total++;
      if (!ok || product !== ev) begin
        bad++;
        $display("FAIL random_product: %0d*%0d ok=%0d got %b want %b", av, bv, ok, product, ev);
      end
      $display("random %0d*%0d: product=%0d latency=%0d", av, bv, product, lat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_run();
    test_zero_operand();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
